// File: rtl/ntt_op_sequencer.sv
// Command queue and phase sequencer that steps the NTT/PWM/INTT index-generator FSM
// through RUN, pipeline drain and IDLE, reporting per-operation completion.
module ntt_op_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 9,
  parameter int TIMEOUT      = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic                          abort,
  input  logic [3:0]                    done_flag,
  output logic [2:0]                    conf,
  output logic                          busy,
  output logic                          op_done,
  output logic [1:0]                    op_done_code,
  output logic                          op_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic [1:0]    op;
  logic [WW-1:0] wdog;
  logic [DW-1:0] drain_cnt;
  logic          err;

  logic [1:0]    head;
  logic          push;
  logic          pop;
  logic          done_hit;
  logic          timeout;
  logic          run_exit;
  logic [2:0]    run_code;
  logic [2:0]    drain_code;

  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign cmd_ready  = (level < LW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready && !abort;
  assign pop        = (state == IDLE) && (level != '0) && !abort;
  assign busy       = (state != IDLE) || (level != '0);

  assign done_hit   = done_flag[op];
  assign timeout    = (wdog == WW'(TIMEOUT));
  assign run_exit   = (state == RUN) && (done_hit || timeout || abort);
  assign run_code   = {1'b0, op} + 3'd1;
  assign drain_code = (op == 2'd2) ? 3'd5 : 3'd4;

  // The drain code must reach the FSM in the same cycle the last index retires,
  // so conf is decoded combinationally rather than registered.
  always_comb begin
    conf = 3'd0;
    case (state)
      RUN:     conf = run_exit ? drain_code : run_code;
      DRAIN:   conf = drain_code;
      default: conf = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Exit from RUN counts as the first drain cycle, so DRAIN itself lasts DRAIN_CYCLES-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op           <= 2'd0;
      wdog         <= '0;
      drain_cnt    <= '0;
      err          <= 1'b0;
      op_done      <= 1'b0;
      op_done_code <= 2'd0;
      op_err       <= 1'b0;
    end else begin
      op_done <= 1'b0;
      op_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            if (head == 2'd3) begin
              op_done      <= 1'b1;
              op_err       <= 1'b1;
              op_done_code <= 2'd3;
            end else begin
              op    <= head;
              wdog  <= '0;
              err   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (run_exit) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            err       <= abort || (timeout && !done_hit);
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DRAIN: begin
          if (abort) err <= 1'b1;
          if (drain_cnt == DW'(DRAIN_CYCLES - 2)) begin
            state        <= IDLE;
            op_done      <= 1'b1;
            op_err       <= err || abort;
            op_done_code <= op;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
